// File: rtl/if_df_pkg.sv
// Shared definitions for the fetch/decode pipeline boundary.
//   stage_state_e : occupancy of a two-entry skid stage
//   PC_W_DEF / INST_W_DEF : default field widths used by fetch and decode
//   NOP_INST_DEF : bubble instruction presented while no pair is valid
package if_df_pkg;

  localparam int unsigned PC_W_DEF   = 16;
  localparam int unsigned INST_W_DEF = 16;

  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring.
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-low, clears count
//   inc   : increment request for this cycle
//   count : current value; sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_df_skid_stage.sv
// Fetch-to-decode pipeline stage with valid/ready handshake and a two-entry
// skid buffer (main register drives the outputs, skid register catches the
// beat in flight when decode stalls).
//   clk, rst (sync, active-low), flush (sync, active-high)
//   in_valid / in_ready (registered) / in_pc / in_inst : from fetch
//   out_valid / out_ready / out_pc / out_inst          : to decode
//   stall_cnt : saturating count of cycles with out_valid=1, out_ready=0
module if_df_skid_stage
  import if_df_pkg::*;
#(
  parameter int unsigned        PC_W     = PC_W_DEF,
  parameter int unsigned        INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF),
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e state_q, state_d;

  logic              in_ready_q;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  // Valid bits of main and skid are encoded by the state itself:
  // main valid <=> state != EMPTY, skid valid <=> state == FULL.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  assign out_pc   = out_valid ? main_pc   : '0;
  assign out_inst = out_valid ? main_inst : NOP_INST;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards both entries and any pair accepted this cycle.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_pc    <= '0;
      main_inst  <= NOP_INST;
      skid_pc    <= '0;
      skid_inst  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_main_in) begin
        main_pc   <= in_pc;
        main_inst <= in_inst;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end
      if (load_skid) begin
        skid_pc   <= in_pc;
        skid_inst <= in_inst;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_if_df_skid_stage.sv
module tb_if_df_skid_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_pc, in_inst, out_pc, out_inst;
  logic [3:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_df_skid_stage #(
    .PC_W    (16),
    .INST_W  (16),
    .NOP_INST(16'h0000),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .stall_cnt(stall_cnt)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 16'h0055; in_inst = 16'h1234;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_inst !== 16'h0000) begin failures++; $display("FAIL reset_out_inst: got %h expected 0000", out_inst); end
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL reset_out_pc: got %h expected 0000", out_pc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_pc    = 16'h0010 + 16'(i);
      in_inst  = 16'hA000 + 16'(i);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0010 + 16'(i) || out_inst !== 16'hA000 + 16'(i)) begin
        failures++;
        $display("FAIL stream_out[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained: got %b expected 0", out_valid); end
    checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL stream_no_stall: got %h expected 0", stall_cnt); end
  endtask

  task automatic test_skid();
    in_valid = 1'b1; in_pc = 16'h0020; in_inst = 16'hB020; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_pc = 16'h0021; in_inst = 16'hB021;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_before: got %b expected 1", in_ready); end
    tick();
    in_pc = 16'h0022; in_inst = 16'hB022;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_ready_full: got %b expected 0", in_ready); end
    checks++; if (out_pc !== 16'h0020 || out_inst !== 16'hB020) begin failures++; $display("FAIL skid_hold1: got pc=%h inst=%h expected pc=0020 inst=B020", out_pc, out_inst); end
    checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL skid_stall1: got %0d expected 1", stall_cnt); end
    tick(); tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 16'h0020) begin failures++; $display("FAIL skid_hold3: got ready=%b pc=%h expected ready=0 pc=0020", in_ready, out_pc); end
    checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL skid_stall3: got %0d expected 3", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0021 || out_inst !== 16'hB021) begin failures++; $display("FAIL skid_drain1: got v=%b pc=%h inst=%h expected v=1 pc=0021 inst=B021", out_valid, out_pc, out_inst); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_reopen: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0022 || out_inst !== 16'hB022) begin failures++; $display("FAIL skid_drain2: got v=%b pc=%h inst=%h expected v=1 pc=0022 inst=B022", out_valid, out_pc, out_inst); end
    checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL skid_stall_hold: got %0d expected 3", stall_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush_full();
    in_valid = 1'b1; in_pc = 16'h0030; in_inst = 16'hC030; out_ready = 1'b0;
    tick();
    in_pc = 16'h0031; in_inst = 16'hC031;
    tick();
    checks++; if (in_ready !== 1'b0 || stall_cnt !== 4'd4) begin failures++; $display("FAIL flush_prefill: got ready=%b cnt=%0d expected ready=0 cnt=4", in_ready, stall_cnt); end
    flush = 1'b1; in_pc = 16'h0032; in_inst = 16'hC032;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_inst !== 16'h0000 || out_pc !== 16'h0000) begin failures++; $display("FAIL flush_outputs: got v=%b pc=%h inst=%h expected v=0 pc=0000 inst=0000", out_valid, out_pc, out_inst); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    checks++; if (stall_cnt !== 4'd5) begin failures++; $display("FAIL flush_keeps_cnt: got %0d expected 5", stall_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_delivery: got %b expected 0", out_valid); end
    // A pair accepted in the flush cycle itself is discarded.
    in_valid = 1'b1; flush = 1'b1; in_pc = 16'h0040; in_inst = 16'hC040;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard_accept: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_pc = 16'h0050; in_inst = 16'hD050; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_stop: got %h expected F", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0050 || out_inst !== 16'hD050) begin failures++; $display("FAIL sat_hold_data: got v=%b pc=%h inst=%h expected v=1 pc=0050 inst=D050", out_valid, out_pc, out_inst); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_after_flush: got %h expected F", stall_cnt); end
    // Refill to FULL, then reset mid-transfer with flush and in_valid also high.
    in_valid = 1'b1; in_pc = 16'h0060; tick(); in_pc = 16'h0061; tick();
    rst = 1'b0; flush = 1'b1;
    tick();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL sat_rst_clear: got %h expected 0", stall_cnt); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 16'h0000) begin failures++; $display("FAIL rst_midtransfer: got v=%b ready=%b pc=%h expected v=0 ready=1 pc=0000", out_valid, in_ready, out_pc); end
  endtask

  task automatic test_random();
    pair_t       q[$];
    logic [3:0]  sc;
    logic        exp_v, fire_in, fire_out;
    logic [15:0] exp_pc, exp_inst;
    sc = 4'h0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      exp_v    = (q.size() > 0);
      exp_pc   = exp_v ? q[0].pc   : 16'h0000;
      exp_inst = exp_v ? q[0].inst : 16'h0000;
      checks++;
      if (out_valid !== exp_v || out_pc !== exp_pc || out_inst !== exp_inst) begin
        failures++;
        $display("FAIL rand_out@%0d: got v=%b pc=%h inst=%h expected v=%b pc=%h inst=%h",
                 cyc, out_valid, out_pc, out_inst, exp_v, exp_pc, exp_inst);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_in_ready@%0d: got %b expected %b", cyc, in_ready, q.size() < 2); end
      checks++;
      if (stall_cnt !== sc) begin failures++; $display("FAIL rand_stall_cnt@%0d: got %h expected %h", cyc, stall_cnt, sc); end
      if (failures > 50) break;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = 16'($urandom);
      in_inst   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      fire_in   = in_valid && (q.size() < 2);
      fire_out  = exp_v && out_ready;
      if (exp_v && !out_ready && sc != 4'hF) sc = sc + 4'd1;
      tick();
      if (flush) begin
        q.delete();
      end else begin
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back('{pc: in_pc, inst: in_inst});
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_df_skid_stage.md
# if_df_skid_stage

Parametrised fetch-to-decode pipeline stage with a valid/ready handshake and a two-entry skid buffer. It carries the (PC, instruction) pair from instruction fetch into decode. It sustains one transfer per cycle under backpressure, supports a synchronous flush that turns in-flight entries into bubbles, and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- PC_W, 16, PC field width
- INST_W, 16, instruction field width
- NOP_INST, 16'h0000 (INST_W bits), instruction driven on out_inst while out_valid=0
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  synchronous flush, active-high
- in_valid  in  1  fetch presents a valid pair
- in_ready  out  1  stage can accept; registered
- in_pc  in  PC_W  fetched PC
- in_inst  in  INST_W  fetched instruction
- out_valid  out  1  pair valid toward decode
- out_ready  in  1  decode accepts
- out_pc  out  PC_W  PC to decode
- out_inst  out  INST_W  instruction to decode
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Storage: main register (drives outputs) and skid register, each with a valid bit.
- Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY: no entries.
  - ONE: main valid.
  - FULL: main and skid valid.
- EMPTY: in_fire -> ONE; main loads input.
- ONE:
  - in_fire & out_fire -> ONE; main loads input.
  - in_fire & !out_ready -> FULL; skid loads input.
  - !in_fire & out_fire -> EMPTY.
  - otherwise hold.
- FULL:
  - out_fire -> ONE; main loads skid.
  - otherwise hold.
  - in_ready=0, so no input is accepted.
- in_ready = (state != FULL), registered from next state.
- Held data is stable while out_valid=1 and out_ready=0.
- Output gating while out_valid=0: out_pc=0, out_inst=NOP_INST.
- Flush: next state EMPTY, both valid bits cleared. A pair accepted in the flush cycle is discarded. in_ready=1 the cycle after flush.
- Priority: rst > flush > normal operation.
- stall_cnt: +1 on each cycle with out_valid & !out_ready. Holds at all-ones. Cleared only by rst; flush does not clear it.

## Timing
- Reset values:
  - state EMPTY
  - out_valid=0, out_pc=0, out_inst=NOP_INST
  - in_ready=1
  - stall_cnt=0
- Latency: a pair accepted at edge N appears on out_* with out_valid=1 after edge N (visible cycle N+1) if the stage was EMPTY, or ONE with out_fire.
- Throughput: 1 pair/cycle with out_ready held high.
- Backpressure: out_ready dropping for one cycle costs no throughput. The skid absorbs the in-flight beat. in_ready falls one cycle later.
- Ordering: strictly FIFO; no pair is duplicated or dropped except by flush.
- rst asserted mid-transfer: all state returns to reset values at that edge regardless of in_valid/flush.
- flush and rst both asserted: rst behaviour.

## Structure
- Shared package if_df_pkg:
  - state enum {EMPTY, ONE, FULL}
  - default NOP_INST constant
  - PC_W/INST_W defaults reused by the fetch and decode stages
- One sub-module: sat_counter (parameter WIDTH; ports clk, rst, inc, count). Instantiated for stall_cnt and reusable by other pipeline stages.
- The handshake FSM and data registers stay in the top module.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_inst=16'h0000, out_pc=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1; push PC 0x0010..0x0017 with inst 0xA000+i on consecutive cycles -> same 8 pairs out in order, one per cycle, first visible 1 cycle after first accept.
- Skid: push 0x0020, 0x0021, 0x0022 back-to-back while out_ready=0 from the second cycle:
  - in_ready=0 after 0x0021 is accepted; 0x0022 is held at the input and not taken.
  - stall_cnt counts each stalled cycle.
  - releasing out_ready drains 0x0020, 0x0021, 0x0022 in order.
- Flush in FULL: fill both entries, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_inst=NOP_INST, in_ready=1, flushed input not delivered.
- Stall saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF; flush leaves it at 4'hF; rst clears it to 0.
- Random: random in_valid/out_ready/occasional flush for 10k cycles against a reference queue model -> no loss, duplication or reordering outside flushes; out_* stable while stalled.
